rst_seq: RTL and testbench
==========================

RST_SEQ -- requirements
Module: rst_seq

Interface
REQ-001 Parameter: CNT_W, 16, width of the shared delay counter.
REQ-002 Parameter: LOCK_CYC, 16, consecutive pll_locked_i=1 cycles needed before sequencing (1..2^CNT_W).
REQ-003 Parameter: DLY_CORE, 8, cycles between lock qualification and core reset release (1..2^CNT_W).
REQ-004 Parameter: DLY_PERIPH, 8, cycles between core and peripheral reset release (1..2^CNT_W).
REQ-005 Port: clk_i  in  1  single clock; all logic on the rising edge.
REQ-006 Port: rstn_i  in  1  synchronous, active-low reset; this is the global power-on reset.
REQ-007 Port: pll_locked_i  in  1  PLL lock status, already synchronous to clk_i.
REQ-008 Port: sw_rst_i  in  1  single-cycle software re-sequence request.
REQ-009 Port: clr_i  in  1  single-cycle clear of lock-loss status.
REQ-010 Port: core_rstn_o  out  1  active-low core reset.
REQ-011 Port: periph_rstn_o  out  1  active-low peripheral reset.
REQ-012 Port: ready_o  out  1  sequence complete.
REQ-013 Port: lock_lost_o  out  1  sticky lock-loss flag.
REQ-014 Port: loss_cnt_o  out  8  count of lock-loss events, saturating.

Function
REQ-015 The FSM SHALL have the states LOCK, DLY, PERIPH and RUN; after reset it SHALL be in LOCK with counter=0.
REQ-016 LOCK: the counter SHALL increment on each cycle with pll_locked_i=1 and clear on pll_locked_i=0; on the edge where counter=LOCK_CYC-1 and pll_locked_i=1, the FSM SHALL go to DLY and clear the counter.
REQ-017 DLY: the counter SHALL count cycles; at counter=DLY_CORE-1 the FSM SHALL go to PERIPH and clear the counter.
REQ-018 PERIPH: the counter SHALL count cycles; at counter=DLY_PERIPH-1 the FSM SHALL go to RUN; RUN SHALL hold indefinitely.
REQ-019 Outputs SHALL be decoded directly from the state register with no extra latency: core_rstn_o=1 in PERIPH and RUN; periph_rstn_o=1 and ready_o=1 in RUN only.
REQ-020 With pll_locked_i held high, taking the first edge with rstn_i=1 as edge 1: core_rstn_o SHALL rise after edge LOCK_CYC+DLY_CORE, and periph_rstn_o and ready_o SHALL rise after edge LOCK_CYC+DLY_CORE+DLY_PERIPH.
REQ-021 In DLY, PERIPH or RUN, a sampled pll_locked_i=0 SHALL cause, at that edge: a return to LOCK, counter=0, lock_lost_o=1, and loss_cnt_o+1 (saturating at 255).
REQ-022 sw_rst_i=1 in DLY, PERIPH or RUN SHALL cause a return to LOCK with counter=0 and SHALL NOT affect lock_lost_o or loss_cnt_o; in LOCK it SHALL clear the counter.
REQ-023 If sw_rst_i and a lock loss occur on the same edge, the event SHALL be treated as a lock loss (counted).
REQ-024 clr_i SHALL clear lock_lost_o and loss_cnt_o; if it coincides with a lock loss, the result SHALL be lock_lost_o=1 and loss_cnt_o=1.
REQ-025 loss_cnt_o at 255 SHALL remain 255 on further losses while lock_lost_o stays 1.

Reset
REQ-026 While rstn_i=0: state=LOCK, counter=0, core_rstn_o=0, periph_rstn_o=0, ready_o=0, lock_lost_o=0, loss_cnt_o=0.
REQ-027 A reset asserted mid-sequence or in RUN SHALL take effect at the next edge and override all other inputs.

Structure
REQ-028 The state encoding and the loss-counter width (8) SHALL live in the shared package rst_seq_pkg.
REQ-029 The module SHALL be flat with one shared down-phase counter and no sub-module; parameter ranges SHALL be checked by an elaboration-time assertion.

Verification
REQ-030 Defaults, pll_locked_i=1 from reset release -> core_rstn_o rises after edge 24, periph_rstn_o/ready_o after edge 32.
REQ-031 pll_locked_i toggles low at edge 10, then stays high -> core_rstn_o rises 16+8 edges after relock; lock_lost_o stays 0.
REQ-032 In RUN, pll_locked_i low for 1 cycle -> all resets low next edge, lock_lost_o=1, loss_cnt_o=1, re-release after 24/32 edges.
REQ-033 In PERIPH, sw_rst_i and pll loss on the same edge -> LOCK, loss_cnt_o increments; sw_rst_i alone in RUN -> LOCK, loss_cnt_o unchanged.
REQ-034 300 lock losses -> loss_cnt_o=255; clr_i coinciding with a loss -> lock_lost_o=1, loss_cnt_o=1.
REQ-035 rstn_i asserted in DLY -> all outputs 0 next edge; after release, sequence restarts from LOCK.

Source files
------------

// File: rtl/rst_seq_pkg.sv
// Shared types for the reset sequencer: FSM state encoding, loss-counter width
// and the saturating increment used for lock-loss counting.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    ST_LOCK   = 2'd0,
    ST_DLY    = 2'd1,
    ST_PERIPH = 2'd2,
    ST_RUN    = 2'd3
  } state_t;

  localparam int LOSS_W = 8;
  localparam logic [LOSS_W-1:0] LOSS_MAX = {LOSS_W{1'b1}};

  function automatic logic [LOSS_W-1:0] sat_inc(input logic [LOSS_W-1:0] v);
    return (v == LOSS_MAX) ? v : v + LOSS_W'(1);
  endfunction

endpackage

// File: rtl/rst_seq.sv
// Power-on reset sequencer: qualifies PLL lock, then releases core and
// peripheral resets in order using one shared phase counter.
module rst_seq
  import rst_seq_pkg::*;
#(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned LOCK_CYC   = 16,
  parameter int unsigned DLY_CORE   = 8,
  parameter int unsigned DLY_PERIPH = 8
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              pll_locked_i,
  input  logic              sw_rst_i,
  input  logic              clr_i,
  output logic              core_rstn_o,
  output logic              periph_rstn_o,
  output logic              ready_o,
  output logic              lock_lost_o,
  output logic [LOSS_W-1:0] loss_cnt_o
);

  localparam longint MAX_CYC = longint'(1) << CNT_W;

  if (LOCK_CYC < 1 || longint'(LOCK_CYC) > MAX_CYC ||
      DLY_CORE < 1 || longint'(DLY_CORE) > MAX_CYC ||
      DLY_PERIPH < 1 || longint'(DLY_PERIPH) > MAX_CYC) begin : g_param_err
    $error("rst_seq: LOCK_CYC/DLY_CORE/DLY_PERIPH must lie in 1..2^CNT_W");
  end

  localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_CYC - 1);
  localparam logic [CNT_W-1:0] CORE_LAST   = CNT_W'(DLY_CORE - 1);
  localparam logic [CNT_W-1:0] PERIPH_LAST = CNT_W'(DLY_PERIPH - 1);

  state_t            state_r, state_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic              lost_r, lost_s;
  logic [LOSS_W-1:0] loss_cnt_r, loss_cnt_s;
  logic              loss_ev_s;

  // Next-state, phase counter and lock-loss bookkeeping.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    lost_s     = lost_r;
    loss_cnt_s = loss_cnt_r;
    loss_ev_s  = 1'b0;

    case (state_r)
      ST_LOCK: begin
        if (!pll_locked_i || sw_rst_i) begin
          cnt_s = '0;
        end else if (cnt_r == LOCK_LAST) begin
          state_s = ST_DLY;
          cnt_s   = '0;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      ST_DLY, ST_PERIPH, ST_RUN: begin
        // Lock loss outranks a coincident software request so it is counted.
        if (!pll_locked_i) begin
          state_s   = ST_LOCK;
          cnt_s     = '0;
          loss_ev_s = 1'b1;
        end else if (sw_rst_i) begin
          state_s = ST_LOCK;
          cnt_s   = '0;
        end else if (state_r == ST_DLY) begin
          if (cnt_r == CORE_LAST) begin
            state_s = ST_PERIPH;
            cnt_s   = '0;
          end else begin
            cnt_s = cnt_r + CNT_W'(1);
          end
        end else if (state_r == ST_PERIPH) begin
          if (cnt_r == PERIPH_LAST) begin
            state_s = ST_RUN;
            cnt_s   = '0;
          end else begin
            cnt_s = cnt_r + CNT_W'(1);
          end
        end else begin
          cnt_s = '0;
        end
      end
      default: begin
        state_s = ST_LOCK;
        cnt_s   = '0;
      end
    endcase

    if (loss_ev_s) begin
      lost_s     = 1'b1;
      loss_cnt_s = clr_i ? LOSS_W'(1) : sat_inc(loss_cnt_r);
    end else if (clr_i) begin
      lost_s     = 1'b0;
      loss_cnt_s = '0;
    end else begin
      lost_s     = lost_r;
      loss_cnt_s = loss_cnt_r;
    end
  end

  // State, counter and status registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_r    <= ST_LOCK;
      cnt_r      <= '0;
      lost_r     <= 1'b0;
      loss_cnt_r <= '0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      lost_r     <= lost_s;
      loss_cnt_r <= loss_cnt_s;
    end
  end

  assign core_rstn_o   = (state_r == ST_PERIPH) || (state_r == ST_RUN);
  assign periph_rstn_o = (state_r == ST_RUN);
  assign ready_o       = (state_r == ST_RUN);
  assign lock_lost_o   = lost_r;
  assign loss_cnt_o    = loss_cnt_r;

endmodule

// File: tb/tb_rst_seq.sv
// Directed bench for rst_seq with default parameters; expected values are
// hand-derived edge counts from reset release or relock.
module tb_rst_seq;

  logic       clk_i = 1'b0;
  logic       rstn_i = 1'b0;
  logic       pll_locked_i = 1'b0;
  logic       sw_rst_i = 1'b0;
  logic       clr_i = 1'b0;
  logic       core_rstn_o;
  logic       periph_rstn_o;
  logic       ready_o;
  logic       lock_lost_o;
  logic [7:0] loss_cnt_o;

  int n_checks = 0;
  int n_errors = 0;

  rst_seq dut (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .pll_locked_i (pll_locked_i),
    .sw_rst_i     (sw_rst_i),
    .clr_i        (clr_i),
    .core_rstn_o  (core_rstn_o),
    .periph_rstn_o(periph_rstn_o),
    .ready_o      (ready_o),
    .lock_lost_o  (lock_lost_o),
    .loss_cnt_o   (loss_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance n rising edges; inputs change and outputs are sampled 1ns later.
  task automatic step(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic check_all(input string tag, input logic c, input logic p,
                           input logic r, input logic l, input logic [7:0] n);
    check({tag, ".core"},   {7'd0, core_rstn_o},   {7'd0, c});
    check({tag, ".periph"}, {7'd0, periph_rstn_o}, {7'd0, p});
    check({tag, ".ready"},  {7'd0, ready_o},       {7'd0, r});
    check({tag, ".lost"},   {7'd0, lock_lost_o},   {7'd0, l});
    check({tag, ".lcnt"},   loss_cnt_o,            n);
  endtask

  initial begin
    // Reset state
    rstn_i = 1'b0; pll_locked_i = 1'b1;
    step(3);
    check_all("rst", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);

    // Nominal sequence: core after edge 24, periph/ready after edge 32
    rstn_i = 1'b1;
    step(23);
    check_all("nom23", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    step(1);
    check_all("nom24", 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    step(7);
    check_all("nom31", 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    step(1);
    check_all("nom32", 1'b1, 1'b1, 1'b1, 1'b0, 8'd0);
    step(20);
    check_all("run_hold", 1'b1, 1'b1, 1'b1, 1'b0, 8'd0);

    // One-cycle lock loss in RUN, then re-release
    pll_locked_i = 1'b0;
    step(1);
    pll_locked_i = 1'b1;
    check_all("loss_run", 1'b0, 1'b0, 1'b0, 1'b1, 8'd1);
    step(23);
    check("reloss23.core", {7'd0, core_rstn_o}, 8'd0);
    step(1);
    check("reloss24.core", {7'd0, core_rstn_o}, 8'd1);
    step(7);
    check("reloss31.ready", {7'd0, ready_o}, 8'd0);
    step(1);
    check_all("reloss32", 1'b1, 1'b1, 1'b1, 1'b1, 8'd1);

    // Software request alone in RUN: back to LOCK, count unchanged
    sw_rst_i = 1'b1;
    step(1);
    sw_rst_i = 1'b0;
    check_all("sw_run", 1'b0, 1'b0, 1'b0, 1'b1, 8'd1);
    step(24);
    check_all("to_periph", 1'b1, 1'b0, 1'b0, 1'b1, 8'd1);

    // Software request with lock loss in PERIPH: counted as a loss
    sw_rst_i = 1'b1; pll_locked_i = 1'b0;
    step(1);
    sw_rst_i = 1'b0; pll_locked_i = 1'b1;
    check_all("sw_loss", 1'b0, 1'b0, 1'b0, 1'b1, 8'd2);

    // Lock dropout while still in LOCK only restarts qualification
    rstn_i = 1'b0;
    step(2);
    check_all("rst2", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    rstn_i = 1'b1;
    step(9);
    pll_locked_i = 1'b0;
    step(1);
    pll_locked_i = 1'b1;
    step(23);
    check_all("relock23", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    step(1);
    check_all("relock24", 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);

    // Plain clear
    pll_locked_i = 1'b0;
    step(1);
    pll_locked_i = 1'b1;
    check_all("pre_clr", 1'b0, 1'b0, 1'b0, 1'b1, 8'd1);
    clr_i = 1'b1;
    step(1);
    clr_i = 1'b0;
    check_all("clr", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);

    // 300 losses saturate the counter at 255
    for (int i = 0; i < 300; i++) begin
      pll_locked_i = 1'b1;
      step(16);
      pll_locked_i = 1'b0;
      step(1);
      if (i == 9) check("lcnt10", loss_cnt_o, 8'd10);
      if (i == 254) check("lcnt255", loss_cnt_o, 8'd255);
    end
    check_all("sat", 1'b0, 1'b0, 1'b0, 1'b1, 8'd255);

    // Clear coinciding with a loss
    pll_locked_i = 1'b1;
    step(16);
    pll_locked_i = 1'b0; clr_i = 1'b1;
    step(1);
    clr_i = 1'b0; pll_locked_i = 1'b1;
    check_all("clr_loss", 1'b0, 1'b0, 1'b0, 1'b1, 8'd1);

    // Reset in DLY overrides everything, then the sequence restarts
    step(19);
    rstn_i = 1'b0; sw_rst_i = 1'b1; clr_i = 1'b0;
    step(1);
    sw_rst_i = 1'b0;
    check_all("rst_dly", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    rstn_i = 1'b1;
    step(23);
    check("rst_dly23.core", {7'd0, core_rstn_o}, 8'd0);
    step(1);
    check("rst_dly24.core", {7'd0, core_rstn_o}, 8'd1);
    step(8);
    check_all("rst_dly32", 1'b1, 1'b1, 1'b1, 1'b0, 8'd0);

    // Reset in RUN
    rstn_i = 1'b0;
    step(1);
    check_all("rst_run", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
